vrased_reset_ctrl: RTL
======================

Name: vrased_reset_ctrl

Overview:
Downstream consumer of the per-monitor `reset` outputs (DMA/stack, key access, atomicity, etc.). Merges N violation requests into the single MCU reset.
- Stretches each reset to a minimum hold time.
- Releases only once the CPU is fetching at the reset handler and every monitor is quiet.
- Records which monitors fired and counts violations for debug/attestation telemetry.

Parameters:
N_MON, 4, number of monitor reset-request inputs (1..16)
RESET_HANDLER, 16'h0000, PC value that qualifies reset release
RST_HOLD, 4, minimum cycles `reset` stays high after a new violation (1..255)
CNT_W, 8, width of saturating violation counter

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
pc  in  16  current CPU program counter
mon_req  in  N_MON  reset requests from monitors, bit i = monitor i, level-sensitive
reset  out  1  merged MCU reset, active-high
cause  out  N_MON  sticky mask of monitors that fired in the current reset episode
viol_cnt  out  CNT_W  saturating count of reset episodes entered from RUN
in_reset  out  1  high while state != RUN (equals `reset`, provided separately for debug taps)

Behaviour:
- Any request: any_req = |mon_req.
- States: RUN, HOLD, WAIT_PC. State register, hold counter `hcnt` (8 bit), `cause` and `viol_cnt` are all registers.
- Output decode: reset = in_reset = (state != RUN), decoded from the state register. Latency from mon_req rising in RUN to reset high is exactly 1 clk.
- rst=1 at a clock edge:
  - state <= HOLD, hcnt <= RST_HOLD-1, cause <= 0, viol_cnt <= 0.
  - Result: reset is high out of reset (power-on = kill, matching the monitors' initial state).
  - rst overrides every other event in that cycle.
- RUN:
  - any_req=1 -> HOLD; hcnt <= RST_HOLD-1; cause <= mon_req (replaces the old mask); viol_cnt <= viol_cnt+1, saturating at all-ones.
  - Otherwise stay in RUN; cause and viol_cnt hold.
- HOLD:
  - cause <= cause | mon_req each cycle.
  - any_req=1 -> hcnt reloads RST_HOLD-1 and state stays HOLD (hold time restarts).
  - Else if hcnt==0 -> WAIT_PC.
  - Else hcnt <= hcnt-1.
  - viol_cnt never increments here.
  - With RST_HOLD=1 and no request, HOLD lasts exactly 1 cycle.
- WAIT_PC:
  - cause <= cause | mon_req.
  - any_req=1 -> HOLD with hcnt reload. The request wins even if pc==RESET_HANDLER in the same cycle.
  - Else pc==RESET_HANDLER -> RUN; reset drops 1 clk later.
  - Else stay in WAIT_PC.
- Total reset width for an isolated violation in RUN is at least RST_HOLD+1 cycles.
- cause is not cleared on the return to RUN; it stays readable until the next episode from RUN overwrites it, or until rst.
- viol_cnt counts episodes, not request cycles. A request held high for many cycles counts once per RUN->HOLD entry.
- No combinational path from mon_req or pc to reset.

Test Plan:
1. Power-on: rst=1 for 2 clks, then rst=0, RST_HOLD=4, mon_req=0, pc=16'hE000 for 10 clks, then pc=16'h0000 -> reset=1 throughout; state HOLD for 4 clks then WAIT_PC; reset=0 on the clk after pc==0000 is sampled; viol_cnt=0, cause=0.
2. Single violation: in RUN, pulse mon_req=4'b0010 for 1 clk with pc=0000 held -> reset=1 the next clk, high for exactly 5 clks (RST_HOLD+1), then 0; cause=4'b0010; viol_cnt=1.
3. Hold restart and accumulation: in HOLD with hcnt=1, assert mon_req=4'b1000 for 1 clk -> hcnt reloads to 3, reset stays high at least 4 more clks, cause=4'b1010, viol_cnt unchanged.
4. Simultaneous request and PC in WAIT_PC: pc=0000 and mon_req=4'b0001 in the same clk -> state goes to HOLD, not RUN; reset stays high; cause gains bit 0.
5. Saturation: with CNT_W=2, drive 5 separate violation episodes (each returning to RUN via pc=0000) -> viol_cnt reads 1, 2, 3, 3, 3.
6. Reset mid-episode: rst=1 while in WAIT_PC with cause=4'b0100, viol_cnt=2 -> next clk state=HOLD, cause=0, viol_cnt=0, reset=1.

Source files
------------

// File: rtl/vrased_reset_ctrl_if.sv
// Reset-controller bundle: monitor requests and CPU PC in,
// merged MCU reset and telemetry out.
interface vrased_reset_ctrl_if #(
  parameter int N_MON = 4,
  parameter int CNT_W = 8
);
  logic [15:0]      pc;
  logic [N_MON-1:0] mon_req;
  logic             reset;
  logic [N_MON-1:0] cause;
  logic [CNT_W-1:0] viol_cnt;
  logic             in_reset;

  modport master (
    output pc,
    output mon_req,
    input  reset,
    input  cause,
    input  viol_cnt,
    input  in_reset
  );

  modport slave (
    input  pc,
    input  mon_req,
    output reset,
    output cause,
    output viol_cnt,
    output in_reset
  );
endinterface

// File: rtl/vrased_reset_ctrl.sv
// Merges monitor violation requests into one stretched MCU reset
// that releases only at the reset handler, with cause/count telemetry.
module vrased_reset_ctrl #(
  parameter int          N_MON         = 4,
  parameter logic [15:0] RESET_HANDLER = 16'h0000,
  parameter int          RST_HOLD      = 4,
  parameter int          CNT_W         = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  vrased_reset_ctrl_if.slave   bus
);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    HOLD    = 2'd1,
    WAIT_PC = 2'd2
  } state_t;

  localparam logic [7:0] HOLD_RLD = 8'(RST_HOLD - 1);

  state_t           state, state_n;
  logic [7:0]       hcnt, hcnt_n;
  logic [N_MON-1:0] cause, cause_n;
  logic [CNT_W-1:0] cnt, cnt_n;

  logic any_req;
  logic at_handler;
  logic cnt_sat;

  assign any_req    = |bus.mon_req;
  assign at_handler = (bus.pc == RESET_HANDLER);
  assign cnt_sat    = &cnt;

  // State, hold timer and telemetry registers; rst starts in HOLD
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= HOLD;
      hcnt  <= HOLD_RLD;
      cause <= '0;
      cnt   <= '0;
    end else begin
      state <= state_n;
      hcnt  <= hcnt_n;
      cause <= cause_n;
      cnt   <= cnt_n;
    end
  end

  // Next-state: any request (re)arms the hold, release needs quiet + handler PC
  always_comb begin
    state_n = state;
    hcnt_n  = hcnt;
    cause_n = cause;
    cnt_n   = cnt;
    case (state)
      RUN: begin
        if (any_req) begin
          state_n = HOLD;
          hcnt_n  = HOLD_RLD;
          cause_n = bus.mon_req;
          cnt_n   = cnt_sat ? cnt : cnt + 1'b1;
        end
      end
      HOLD: begin
        cause_n = cause | bus.mon_req;
        if (any_req) begin
          hcnt_n = HOLD_RLD;
        end else if (hcnt == 8'd0) begin
          state_n = WAIT_PC;
        end else begin
          hcnt_n = hcnt - 8'd1;
        end
      end
      WAIT_PC: begin
        cause_n = cause | bus.mon_req;
        if (any_req) begin
          state_n = HOLD;
          hcnt_n  = HOLD_RLD;
        end else if (at_handler) begin
          state_n = RUN;
        end
      end
      default: begin
        state_n = HOLD;
        hcnt_n  = HOLD_RLD;
      end
    endcase
  end

  assign bus.reset    = (state != RUN);
  assign bus.in_reset = (state != RUN);
  assign bus.cause    = cause;
  assign bus.viol_cnt = cnt;

endmodule
